// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer
// Feeds operand pairs from a small FIFO to a Booth multiplier core one job at
// a time, waits a fixed latency, captures the product and offers it on a
// valid/ready output. Everything, including the FIFO pointers, is cleared by
// a synchronous active-low reset.
module booth_operand_sequencer #(
    parameter int SIZE       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = SIZE + 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SIZE-1:0]                   in_multiplier,
    input  logic [SIZE-1:0]                   in_multiplicand,
    output logic [SIZE-1:0]                   mul_multiplier,
    output logic [SIZE-1:0]                   mul_multiplicand,
    output logic                              mul_start,
    input  logic [2*SIZE-1:0]                 mul_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2*SIZE-1:0]                 out_product,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [2*SIZE-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [2*SIZE-1:0]     fifo_mem_d [FIFO_DEPTH];
    logic [SIZE-1:0]       mul_mplier_q, mul_mplier_d;
    logic [SIZE-1:0]       mul_mcand_q, mul_mcand_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [2*SIZE-1:0]     product_q, product_d;
    logic                  in_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  capture_s;

    // Handshake decode: push on accepted input, pop only when idle with data.
    always_comb begin
        in_ready_s = (count_q < DEPTH_C);
        push_s     = in_valid && in_ready_s;
        pop_s      = (state_q == S_IDLE) && (count_q != {CW{1'b0}});
        capture_s  = (state_q == S_WAIT) && (wait_cnt_q == {WW{1'b0}});
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (capture_s) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy; a simultaneous push and pop keep count.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = {in_multiplier, in_multiplicand};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Job datapath: operand load on pop, latency countdown, product capture.
    always_comb begin
        mul_mplier_d = mul_mplier_q;
        mul_mcand_d  = mul_mcand_q;
        wait_cnt_d   = wait_cnt_q;
        product_d    = product_q;
        if (pop_s) begin
            {mul_mplier_d, mul_mcand_d} = fifo_mem_q[rd_ptr_q];
        end else begin
            mul_mplier_d = mul_mplier_q;
            mul_mcand_d  = mul_mcand_q;
        end
        case (state_q)
            S_START: wait_cnt_d = WAIT_LOAD;
            S_WAIT: begin
                if (capture_s) begin
                    product_d = mul_result;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            default: wait_cnt_d = wait_cnt_q;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            count_q      <= {CW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            mul_mplier_q <= {SIZE{1'b0}};
            mul_mcand_q  <= {SIZE{1'b0}};
            wait_cnt_q   <= {WW{1'b0}};
            product_q    <= {(2*SIZE){1'b0}};
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mul_mplier_q <= mul_mplier_d;
            mul_mcand_q  <= mul_mcand_d;
            wait_cnt_q   <= wait_cnt_d;
            product_q    <= product_d;
        end
    end

    // FIFO array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready         = in_ready_s;
        mul_multiplier   = mul_mplier_q;
        mul_multiplicand = mul_mcand_q;
        mul_start        = (state_q == S_START);
        out_valid        = (state_q == S_HOLD);
        out_product      = product_q;
        busy             = (state_q != S_IDLE);
        count            = count_q;
    end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Scoreboard bench for booth_operand_sequencer: directed operand pairs with
// hand-computed products, a behavioural multiplier core with fixed latency,
// and a monitor that checks every presented product in order.
module tb_booth_operand_sequencer;

    localparam int SIZE  = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = SIZE + 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   in_multiplier;
    logic [SIZE-1:0]   in_multiplicand;
    logic [SIZE-1:0]   mul_multiplier;
    logic [SIZE-1:0]   mul_multiplicand;
    logic              mul_start;
    logic [2*SIZE-1:0] mul_result = 16'hA5A5;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE-1:0] out_product;
    logic              busy;
    logic [CW-1:0]     count;

    booth_operand_sequencer #(.SIZE(SIZE), .FIFO_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_start(mul_start), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_push = 0;
    int last_rise = 0;
    int run_len = 0;
    int last_len = 0;
    int valid_events = 0;
    int starts_total = 0;
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    logic [15:0] sbq[$];
    int start_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: final product valid from cycle k+LAT after a start in cycle k.
    int core_rem = -1;
    logic signed [15:0] core_pend = 16'sd0;
    always @(posedge clk) begin
        if (mul_start) begin
            core_pend = $signed(mul_multiplier) * $signed(mul_multiplicand);
            core_rem  = LAT - 1;
        end else if (core_rem > 0) begin
            core_rem = core_rem - 1;
        end
        mul_result <= (core_rem == 0) ? core_pend : 16'hA5A5;
    end

    // Monitor: pulse-width check on mul_start, in-order product check on out_valid.
    always @(negedge clk) begin
        if (mul_start) begin
            chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
            start_q.push_back(cyc);
            starts_total++;
        end
        prev_start = mul_start;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", out_product, cyc);
            end else begin
                chk("product", {16'd0, out_product}, {16'd0, sbq[0]});
                if (out_ready) void'(sbq.pop_front());
            end
            if (!prev_valid) begin
                last_rise = cyc;
                run_len = 1;
                valid_events++;
            end else begin
                run_len++;
            end
        end else if (prev_valid) begin
            last_len = run_len;
        end
        prev_valid = out_valid;
    end

    task automatic push_try(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                            input int bound, output bit acc);
        in_valid = 1'b1;
        in_multiplier = a;
        in_multiplicand = b;
        acc = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            sbq.push_back(e);
            last_push = cyc;
        end
    endtask

    task automatic push_must(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        bit acc;
        push_try(a, b, e, 60, acc);
        chk("push_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sbq.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_done", sbq.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [7:0]  va[16];
    logic [7:0]  vb[16];
    logic [15:0] ve[16];
    int p0;
    int s0;
    int acc_n;
    int v0;
    bit acc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_multiplier = 8'h00;
        in_multiplicand = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_product", {16'd0, out_product}, 32'd0);
        chk("rst_mul_ops", {16'd0, mul_multiplier, mul_multiplicand}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 3 x 5: out_valid rises on the (LAT+2)th edge after the push edge
        // (LAT+3 edges counting the push edge itself) and lasts one cycle.
        push_must(8'h03, 8'h05, 16'h000F);
        p0 = last_push;
        wait_drain(100);
        chk("t1_latency", last_rise - p0, LAT + 2);
        chk("t1_hold_len", last_len, 32'd1);

        // -3 x 5 then -128 x -128, two single-cycle starts.
        s0 = starts_total;
        push_must(8'hFD, 8'h05, 16'hFFF1);
        push_must(8'h80, 8'h80, 16'h4000);
        wait_drain(100);
        chk("t2_starts", starts_total - s0, 32'd2);

        // Backpressure: six offers, five accepted (one issued, four buffered).
        va = '{8'h01, 8'h02, 8'hFF, 8'h7F, 8'h80, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vb = '{8'h01, 8'h03, 8'hFF, 8'h7F, 8'h7F, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ve = '{16'h0001, 16'h0006, 16'h0001, 16'h3F01, 16'hC080, 16'hFFF2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            push_try(va[i], vb[i], ve[i], 20, acc);
            if (acc) acc_n++;
        end
        chk("t3_accepted", acc_n, 32'd5);
        chk("t3_count_full", {29'd0, count}, 32'd4);
        chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t3_holding", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_drain(300);

        // Simultaneous push and pop at count=2, then ten pairs through the wrap.
        va = '{8'h04, 8'h05, 8'hF9, 8'h0A, 8'hFF, 8'h00, 8'h64, 8'h0C, 8'hCE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vb = '{8'h04, 8'hFB, 8'h09, 8'h0A, 8'h01, 8'h80, 8'h9C, 8'h0C, 8'hCE, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ve = '{16'h0010, 16'hFFE7, 16'hFFC1, 16'h0064, 16'hFFFF, 16'h0000, 16'hD8F0, 16'h0090, 16'h09C4, 16'hC080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_must(va[i], vb[i], ve[i]);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("t4_in_hold", {31'd0, out_valid}, 32'd1);
        chk("t4_count_before", {29'd0, count}, 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_idle", {31'd0, busy}, 32'd0);
        in_valid = 1'b1;
        in_multiplier = va[3];
        in_multiplicand = vb[3];
        @(negedge clk);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sbq.push_back(ve[3]);
        chk("t4_count_simul", {29'd0, count}, 32'd2);
        chk("t4_busy_after_pop", {31'd0, busy}, 32'd1);
        for (int i = 4; i < 10; i++) push_must(va[i], vb[i], ve[i]);
        wait_drain(400);

        // Reset during WAIT with two jobs queued: everything abandoned.
        push_must(8'h02, 8'h02, 16'h0004);
        push_must(8'h03, 8'h03, 16'h0009);
        push_must(8'h04, 8'h04, 16'h0010);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        chk("t5_count_pre", {29'd0, count}, 32'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        chk("t5_count", {29'd0, count}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_mul_start", {31'd0, mul_start}, 32'd0);
        chk("t5_product", {16'd0, out_product}, 32'd0);
        chk("t5_mul_ops", {16'd0, mul_multiplier, mul_multiplicand}, 32'd0);
        v0 = valid_events;
        repeat (3 * LAT) @(posedge clk);
        #1;
        chk("t5_no_output", valid_events - v0, 32'd0);

        // Streaming eight pairs: starts exactly LAT+3 cycles apart.
        va = '{8'h01, 8'hFE, 8'h0F, 8'hF0, 8'h40, 8'hC0, 8'h21, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vb = '{8'h02, 8'h03, 8'h0F, 8'hF0, 8'h02, 8'h02, 8'hFD, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ve = '{16'h0002, 16'hFFFA, 16'h00E1, 16'h0100, 16'h0080, 16'hFF80, 16'hFF9D, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        out_ready = 1'b1;
        start_q.delete();
        for (int i = 0; i < 8; i++) push_must(va[i], vb[i], ve[i]);
        wait_drain(400);
        chk("t6_start_count", start_q.size(), 32'd8);
        if (start_q.size() == 8) begin
            for (int i = 1; i < 8; i++) chk("t6_start_spacing", start_q[i] - start_q[i-1], LAT + 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_operand_sequencer.md
Name: booth_operand_sequencer

Overview:
- Upstream feeder and downstream collector for the Booth multiplier core.
- Accepts operand pairs on a valid/ready input and buffers them in a small FIFO.
- Issues one job at a time to the multiplier: operands plus a one-cycle start pulse.
- Waits a fixed latency, captures the product into a register, then presents it on a valid/ready output.

Parameters:
- SIZE, default `size (8): operand width; product width is 2*SIZE.
- FIFO_DEPTH, default 4: number of buffered operand pairs; power of two, >= 2.
- LATENCY, default SIZE+2: cycles from the mul_start cycle to the cycle in which mul_result holds the final product; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept.
- in_multiplier  in  SIZE  signed operand.
- in_multiplicand  in  SIZE  signed operand.
- mul_multiplier  out  SIZE  to core.
- mul_multiplicand  out  SIZE  to core.
- mul_start  out  1  one-cycle job start pulse to core.
- mul_result  in  2*SIZE  core result.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts.
- out_product  out  2*SIZE  captured signed product.
- busy  out  1  FSM not in IDLE.
- count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst=0 at an edge) clears everything: FIFO emptied, count=0, FSM=IDLE, mul_start=0, mul_multiplier=0, mul_multiplicand=0, out_valid=0, out_product=0, busy=0. in_ready reads 1 after reset.
- Reset mid-job abandons the job with no output; any later mul_result value is ignored.
- FIFO:
  - in_ready = (count < FIFO_DEPTH), combinational from registered count.
  - Push on in_valid && in_ready.
  - Pop only in IDLE with count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full is impossible because in_ready=0. Pop when empty never happens.
  - Pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- FSM states: IDLE, START, WAIT, HOLD.
  - IDLE: if count > 0, pop the head into mul_multiplier/mul_multiplicand and go to START; otherwise stay.
  - START: mul_start=1 for this cycle only; load wait counter = LATENCY-1; go to WAIT.
  - WAIT: if counter == 0, register out_product <= mul_result, set out_valid=1, go to HOLD; else decrement.
  - HOLD: out_valid=1 and out_product stable until out_ready=1. On that edge out_valid clears and FSM goes to IDLE.
- Timing:
  - If mul_start is high in cycle k, capture happens at the edge ending cycle k+LATENCY. out_valid is first seen in cycle k+LATENCY+1.
  - Latency from in_valid&&in_ready edge (empty FIFO, idle FSM) to out_valid: LATENCY+3 edges.
  - Per-job throughput: LATENCY+3 cycles minimum (one IDLE bubble between jobs).
- mul_multiplier/mul_multiplicand hold from the pop edge until the next pop; stable throughout START and WAIT.
- mul_start never asserts outside START, and never for two consecutive cycles.
- Input acceptance continues during WAIT/HOLD; output backpressure only stalls issue, never drops data.
- out_product is the raw 2*SIZE two's-complement value from the core; no truncation or sign manipulation.
- busy = (state != IDLE).

Test Plan:
- SIZE=8: push 3×5 with out_ready=1 -> mul_start one cycle, out_product=16'h000F, out_valid exactly LATENCY+3 edges after the push edge, held one cycle.
- Push -3×5, then -128×-128 -> outputs 16'hFFF1 then 16'h4000 in order; mul_start pulses twice, each one cycle wide.
- Hold out_ready=0 and push 6 pairs in a row -> first product held in HOLD; count reaches 4; in_ready=0; only 5 pushes accepted (1 issued + 4 buffered). Release out_ready -> the remaining 4 products emerge in push order.
- Simultaneous push and pop at count=2 -> count stays 2; ordering preserved across pointer wrap (push 10 pairs through depth 4).
- Assert rst=0 for one cycle during WAIT with 2 items queued -> next cycle all outputs 0, count=0, in_ready=1; no out_valid ever appears for the aborted or queued jobs.
- Stream 8 pairs with out_ready=1 -> mul_start pulses spaced exactly LATENCY+3 cycles apart; all 8 products correct.
